// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline.
// Contents:
//   mem2reg_e    - writeback source codes (REGALU / REGMEM / RPC)
//   branch_e     - branch class codes (BCN / BCB / BCJAL / BCJALR)
//   BUBBLE_ALUOP - ALUOp value carried by an inserted bubble
//   ctrl_t       - control bundle held in every pipeline stage register
//   bubble_ctrl  - returns the bundle that marks an empty stage
//   fwd_select   - encodes an operand-forwarding select from the two hit flags

package ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        REGALU = 2'b00,
        REGMEM = 2'b01,
        RPC    = 2'b10
    } mem2reg_e;

    typedef enum logic [1:0] {
        BCN    = 2'b00,
        BCB    = 2'b01,
        BCJAL  = 2'b10,
        BCJALR = 2'b11
    } branch_e;

    localparam logic [1:0] BUBBLE_ALUOP = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic [1:0] mem2reg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] branch;
        logic [1:0] aluop;
    } ctrl_t;

    // Fully defined bundle, so that x from the decoder is never carried forward.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t b;
        b.valid    = 1'b0;
        b.alusrc   = 1'b0;
        b.mem2reg  = REGALU;
        b.regwrite = 1'b0;
        b.memread  = 1'b0;
        b.memwrite = 1'b0;
        b.branch   = BCN;
        b.aluop    = BUBBLE_ALUOP;
        return b;
    endfunction

    // The MEM stage holds the younger result, so it outranks WB.
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return 2'b10;
        else if (wb_hit)
            return 2'b01;
        else
            return 2'b00;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the decoder/datapath side and ctrl_pipe.
// Parameter: RA_W - register-address width.
// master: the decoder/datapath side. It drives the ID bundle and ex_eq,
//         and it receives the staged controls, the hazard signals and the forward selects.
// slave:  ctrl_pipe itself.

interface ctrl_pipe_if #(parameter int RA_W = 5);

    logic            id_valid;
    logic            id_alusrc;
    logic [1:0]      id_mem2reg;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic [1:0]      id_branch;
    logic [1:0]      id_aluop;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            ex_eq;

    logic            ex_alusrc;
    logic [1:0]      ex_aluop;
    logic [1:0]      ex_branch;
    logic            mem_memread;
    logic            mem_memwrite;
    logic            wb_regwrite;
    logic [1:0]      wb_mem2reg;
    logic [RA_W-1:0] wb_rd;
    logic            stall;
    logic            flush;
    logic            redirect;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    modport master (
        output id_valid, id_alusrc, id_mem2reg, id_regwrite, id_memread,
               id_memwrite, id_branch, id_aluop, id_rs1, id_rs2, id_rd, ex_eq,
        input  ex_alusrc, ex_aluop, ex_branch, mem_memread, mem_memwrite,
               wb_regwrite, wb_mem2reg, wb_rd, stall, flush, redirect, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_alusrc, id_mem2reg, id_regwrite, id_memread,
               id_memwrite, id_branch, id_aluop, id_rs1, id_rs2, id_rd, ex_eq,
        output ex_alusrc, ex_aluop, ex_branch, mem_memread, mem_memwrite,
               wb_regwrite, wb_mem2reg, wb_rd, stall, flush, redirect, fwd_a, fwd_b
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One control pipeline register.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   bubble          - load an empty stage instead of the incoming bundle
//   d_ctrl, d_rs1, d_rs2, d_rd - incoming bundle and register fields
//   q_ctrl, q_rs1, q_rs2, q_rd - registered bundle and register fields

module ctrl_stage_reg import ctrl_pipe_pkg::*; #(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bubble,
    input  ctrl_t           d_ctrl,
    input  logic [RA_W-1:0] d_rs1,
    input  logic [RA_W-1:0] d_rs2,
    input  logic [RA_W-1:0] d_rd,
    output ctrl_t           q_ctrl,
    output logic [RA_W-1:0] q_rs1,
    output logic [RA_W-1:0] q_rs2,
    output logic [RA_W-1:0] q_rd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            q_ctrl <= bubble_ctrl();
            q_rs1  <= '0;
            q_rs2  <= '0;
            q_rd   <= '0;
        end else begin
            q_ctrl <= d_ctrl;
            q_rs1  <= d_rs1;
            q_rs2  <= d_rs2;
            q_rd   <= d_rd;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline. It carries the decoded ID bundle through ID/EX, EX/MEM and MEM/WB.
// It also detects load-use hazards, resolves branch/jump redirects in EX
// and produces the EX operand forwarding selects.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   bus      - ctrl_pipe_if slave modport. It carries the ID bundle and ex_eq in,
//              and the EX/MEM/WB controls, stall, flush, redirect and fwd_a/fwd_b out.

module ctrl_pipe import ctrl_pipe_pkg::*; #(
    parameter int RA_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);

    ctrl_t           id_ctrl;
    ctrl_t           ex_ctrl;
    ctrl_t           mem_ctrl;
    ctrl_t           wb_ctrl;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [RA_W-1:0] mem_rs1, mem_rs2, mem_rd;
    logic [RA_W-1:0] wb_rs1, wb_rs2, wb_rd;
    logic            stall;
    logic            redirect;
    logic            load_bubble;
    logic            wb_unused;

    assign id_ctrl = '{valid:    bus.id_valid,
                       alusrc:   bus.id_alusrc,
                       mem2reg:  bus.id_mem2reg,
                       regwrite: bus.id_regwrite,
                       memread:  bus.id_memread,
                       memwrite: bus.id_memwrite,
                       branch:   bus.id_branch,
                       aluop:    bus.id_aluop};

    // A taken branch or any jump sitting in EX steers the PC and kills the younger ID instruction.
    assign redirect = ex_ctrl.valid &
                      ((ex_ctrl.branch == BCJAL) | (ex_ctrl.branch == BCJALR) |
                       ((ex_ctrl.branch == BCB) & bus.ex_eq));

    // A load in EX whose rd is read by the ID instruction needs one bubble.
    // The instruction is then in MEM, and forwarding from WB covers the next cycle.
    // A redirect squashes the ID instruction instead, so it masks the stall.
    assign stall = ex_ctrl.valid & ex_ctrl.memread & (ex_rd != '0) &
                   ((ex_rd == bus.id_rs1) | (ex_rd == bus.id_rs2)) &
                   bus.id_valid & ~redirect;

    assign load_bubble = ~bus.id_valid | stall | redirect;

    ctrl_stage_reg #(.RA_W(RA_W)) u_id_ex (
        .clk(clk), .rst(rst), .bubble(load_bubble),
        .d_ctrl(id_ctrl), .d_rs1(bus.id_rs1), .d_rs2(bus.id_rs2), .d_rd(bus.id_rd),
        .q_ctrl(ex_ctrl), .q_rs1(ex_rs1), .q_rs2(ex_rs2), .q_rd(ex_rd)
    );

    ctrl_stage_reg #(.RA_W(RA_W)) u_ex_mem (
        .clk(clk), .rst(rst), .bubble(1'b0),
        .d_ctrl(ex_ctrl), .d_rs1(ex_rs1), .d_rs2(ex_rs2), .d_rd(ex_rd),
        .q_ctrl(mem_ctrl), .q_rs1(mem_rs1), .q_rs2(mem_rs2), .q_rd(mem_rd)
    );

    ctrl_stage_reg #(.RA_W(RA_W)) u_mem_wb (
        .clk(clk), .rst(rst), .bubble(1'b0),
        .d_ctrl(mem_ctrl), .d_rs1(mem_rs1), .d_rs2(mem_rs2), .d_rd(mem_rd),
        .q_ctrl(wb_ctrl), .q_rs1(wb_rs1), .q_rs2(wb_rs2), .q_rd(wb_rd)
    );

    // The WB stage uses only its write enable, source and rd. Its other fields end here.
    assign wb_unused = ^{wb_ctrl.valid, wb_ctrl.alusrc, wb_ctrl.memread, wb_ctrl.memwrite,
                         wb_ctrl.branch, wb_ctrl.aluop, wb_rs1, wb_rs2};

    // Forwarding considers only stages that will write a register other than x0.
    always_comb begin
        bus.fwd_a = fwd_select(mem_ctrl.regwrite & (mem_rd != '0) & (mem_rd == ex_rs1),
                               wb_ctrl.regwrite  & (wb_rd  != '0) & (wb_rd  == ex_rs1));
        bus.fwd_b = fwd_select(mem_ctrl.regwrite & (mem_rd != '0) & (mem_rd == ex_rs2),
                               wb_ctrl.regwrite  & (wb_rd  != '0) & (wb_rd  == ex_rs2));
    end

    assign bus.ex_alusrc    = ex_ctrl.alusrc;
    assign bus.ex_aluop     = ex_ctrl.aluop;
    assign bus.ex_branch    = ex_ctrl.branch;
    assign bus.mem_memread  = mem_ctrl.memread;
    assign bus.mem_memwrite = mem_ctrl.memwrite;
    assign bus.wb_regwrite  = wb_ctrl.regwrite;
    assign bus.wb_mem2reg   = wb_ctrl.mem2reg;
    assign bus.wb_rd        = wb_rd;
    assign bus.stall        = stall;
    assign bus.redirect     = redirect;
    assign bus.flush        = redirect;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe. Each scenario task drives ID bundles and checks its own outputs.
// Inputs change at posedge+1. Outputs are sampled before the next edge.

module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam logic [21:0] BUBBLE_VEC = 22'b0_11_00_0_0_0_00_00000_0_0_0_00_00;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ctrl_pipe_if #(.RA_W(5)) bus ();

    ctrl_pipe #(.RA_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All observable outputs packed together, in port order.
    function automatic logic [21:0] outs();
        return {bus.ex_alusrc, bus.ex_aluop, bus.ex_branch, bus.mem_memread, bus.mem_memwrite,
                bus.wb_regwrite, bus.wb_mem2reg, bus.wb_rd, bus.stall, bus.flush, bus.redirect,
                bus.fwd_a, bus.fwd_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic alusrc, input logic [1:0] m2r,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic [1:0] br, input logic [1:0] aluop,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_valid    = v;
        bus.id_alusrc   = alusrc;
        bus.id_mem2reg  = m2r;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_memwrite = mw;
        bus.id_branch   = br;
        bus.id_aluop    = aluop;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
    endtask

    task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        applyStimulus(1'b1, 1'b0, REGALU, 1'b1, 1'b0, 1'b0, BCN, 2'b10, rs1, rs2, rd);
    endtask

    task automatic drive_lw(input logic [4:0] rd, input logic [4:0] rs1);
        applyStimulus(1'b1, 1'b1, REGMEM, 1'b1, 1'b1, 1'b0, BCN, 2'b00, rs1, 5'd0, rd);
    endtask

    task automatic drive_idle();
        applyStimulus(1'b0, 1'b0, REGALU, 1'b0, 1'b0, 1'b0, BCN, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic drain();
        drive_idle();
        bus.ex_eq = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive_add(5'd5, 5'd5, 5'd5);
        repeat (3) tick();
        checks++;
        if (bus.fwd_a !== 2'b10) begin
            errors++; $display("[TB] FAIL rst_pre_fwd_a: got %b expected %b", bus.fwd_a, 2'b10);
        end
        checks++;
        if (bus.wb_rd !== 5'd5 || bus.wb_regwrite !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_pre_wb: got rd=%0d rw=%b expected rd=5 rw=1", bus.wb_rd, bus.wb_regwrite);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== BUBBLE_VEC) begin
            errors++; $display("[TB] FAIL rst_async: got %b expected %b", outs(), BUBBLE_VEC);
        end
        drive_idle();
        #2 rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== BUBBLE_VEC) begin
            errors++; $display("[TB] FAIL rst_release: got %b expected %b", outs(), BUBBLE_VEC);
        end
    endtask

    task automatic test_back_to_back();
        drive_add(5'd5, 5'd1, 5'd2);
        tick();
        drive_add(5'd6, 5'd5, 5'd7);
        tick();
        checks++;
        if (bus.fwd_a !== 2'b10) begin
            errors++; $display("[TB] FAIL b2b_fwd_a_mem: got %b expected %b", bus.fwd_a, 2'b10);
        end
        checks++;
        if (bus.fwd_b !== 2'b00) begin
            errors++; $display("[TB] FAIL b2b_fwd_b_none: got %b expected %b", bus.fwd_b, 2'b00);
        end
        drain();

        drive_add(5'd5, 5'd1, 5'd2);
        tick();
        drive_add(5'd8, 5'd1, 5'd2);
        tick();
        drive_add(5'd6, 5'd5, 5'd7);
        tick();
        checks++;
        if (bus.fwd_a !== 2'b01) begin
            errors++; $display("[TB] FAIL b2b_fwd_a_wb: got %b expected %b", bus.fwd_a, 2'b01);
        end
        drain();

        drive_add(5'd5, 5'd1, 5'd2);
        tick();
        drive_add(5'd5, 5'd3, 5'd4);
        tick();
        drive_add(5'd6, 5'd7, 5'd5);
        tick();
        checks++;
        if (bus.fwd_b !== 2'b10) begin
            errors++; $display("[TB] FAIL b2b_fwd_b_mem_prio: got %b expected %b", bus.fwd_b, 2'b10);
        end
        checks++;
        if (bus.fwd_a !== 2'b00) begin
            errors++; $display("[TB] FAIL b2b_fwd_a_prio_none: got %b expected %b", bus.fwd_a, 2'b00);
        end
        drain();

        drive_add(5'd0, 5'd1, 5'd2);
        tick();
        drive_add(5'd6, 5'd0, 5'd7);
        tick();
        checks++;
        if (bus.fwd_a !== 2'b00) begin
            errors++; $display("[TB] FAIL b2b_fwd_a_x0: got %b expected %b", bus.fwd_a, 2'b00);
        end
        drain();

        applyStimulus(1'b1, 1'b1, REGALU, 1'b0, 1'b0, 1'b1, BCN, 2'b00, 5'd1, 5'd2, 5'd5);
        tick();
        drive_add(5'd6, 5'd5, 5'd7);
        tick();
        checks++;
        if (bus.fwd_a !== 2'b00) begin
            errors++; $display("[TB] FAIL b2b_fwd_a_store: got %b expected %b", bus.fwd_a, 2'b00);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive_lw(5'd5, 5'd1);
        tick();
        drive_add(5'd6, 5'd5, 5'd1);
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.flush !== 1'b0) begin
            errors++; $display("[TB] FAIL lu_stall_on: got stall=%b flush=%b expected stall=1 flush=0", bus.stall, bus.flush);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL lu_stall_one_cycle: got %b expected %b", bus.stall, 1'b0);
        end
        checks++;
        if (bus.ex_aluop !== 2'b11 || bus.ex_alusrc !== 1'b0) begin
            errors++; $display("[TB] FAIL lu_ex_bubble: got aluop=%b alusrc=%b expected aluop=11 alusrc=0", bus.ex_aluop, bus.ex_alusrc);
        end
        checks++;
        if (bus.mem_memread !== 1'b1) begin
            errors++; $display("[TB] FAIL lu_mem_memread: got %b expected %b", bus.mem_memread, 1'b1);
        end
        tick();
        drive_idle();
        checks++;
        if (bus.fwd_a !== 2'b01) begin
            errors++; $display("[TB] FAIL lu_fwd_a_wb: got %b expected %b", bus.fwd_a, 2'b01);
        end
        checks++;
        if (bus.wb_mem2reg !== REGMEM || bus.wb_regwrite !== 1'b1) begin
            errors++; $display("[TB] FAIL lu_wb_load: got m2r=%b rw=%b expected m2r=01 rw=1", bus.wb_mem2reg, bus.wb_regwrite);
        end
        drain();

        drive_lw(5'd0, 5'd1);
        tick();
        drive_add(5'd6, 5'd0, 5'd1);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL lu_x0_no_stall: got %b expected %b", bus.stall, 1'b0);
        end
        drain();
    endtask

    task automatic test_branch();
        applyStimulus(1'b1, 1'b0, REGALU, 1'b0, 1'b0, 1'b0, BCB, 2'b01, 5'd1, 5'd2, 5'd0);
        tick();
        drive_add(5'd7, 5'd1, 5'd2);
        bus.ex_eq = 1'b1;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.flush !== 1'b1 || bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL br_taken: got redirect=%b flush=%b stall=%b expected 1 1 0", bus.redirect, bus.flush, bus.stall);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (bus.redirect !== 1'b0 || bus.ex_aluop !== 2'b11) begin
            errors++; $display("[TB] FAIL br_after: got redirect=%b aluop=%b expected redirect=0 aluop=11", bus.redirect, bus.ex_aluop);
        end
        repeat (2) tick();
        checks++;
        if (bus.wb_regwrite !== 1'b0) begin
            errors++; $display("[TB] FAIL br_squashed_wb: got %b expected %b", bus.wb_regwrite, 1'b0);
        end
        drain();

        applyStimulus(1'b1, 1'b0, REGALU, 1'b0, 1'b0, 1'b0, BCB, 2'b01, 5'd1, 5'd2, 5'd0);
        tick();
        drive_add(5'd7, 5'd1, 5'd2);
        bus.ex_eq = 1'b0;
        #1;
        checks++;
        if (bus.redirect !== 1'b0) begin
            errors++; $display("[TB] FAIL br_not_taken: got %b expected %b", bus.redirect, 1'b0);
        end
        tick();
        checks++;
        if (bus.ex_aluop !== 2'b10) begin
            errors++; $display("[TB] FAIL br_nt_advance: got %b expected %b", bus.ex_aluop, 2'b10);
        end
        drain();
    endtask

    task automatic test_jump_hazard();
        applyStimulus(1'b1, 1'b0, RPC, 1'b1, 1'b0, 1'b0, BCJAL, 2'b00, 5'd0, 5'd0, 5'd1);
        tick();
        drive_add(5'd6, 5'd1, 5'd2);
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL jal_redirect: got redirect=%b stall=%b expected 1 0", bus.redirect, bus.stall);
        end
        tick();
        drive_idle();
        tick();
        checks++;
        if (bus.wb_mem2reg !== RPC || bus.wb_regwrite !== 1'b1 || bus.wb_rd !== 5'd1) begin
            errors++; $display("[TB] FAIL jal_wb: got m2r=%b rw=%b rd=%0d expected m2r=10 rw=1 rd=1", bus.wb_mem2reg, bus.wb_regwrite, bus.wb_rd);
        end
        drain();

        applyStimulus(1'b1, 1'b1, RPC, 1'b1, 1'b1, 1'b0, BCJALR, 2'b00, 5'd3, 5'd0, 5'd5);
        tick();
        drive_add(5'd6, 5'd5, 5'd2);
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.stall !== 1'b0) begin
            errors++; $display("[TB] FAIL jalr_hazard_prio: got redirect=%b stall=%b expected 1 0", bus.redirect, bus.stall);
        end
        tick();
        drive_idle();
        checks++;
        if (bus.ex_aluop !== 2'b11 || bus.ex_branch !== BCN) begin
            errors++; $display("[TB] FAIL jalr_squash: got aluop=%b branch=%b expected aluop=11 branch=00", bus.ex_aluop, bus.ex_branch);
        end
        drain();
    endtask

    task automatic test_x_sanitise();
        applyStimulus(1'b0, 1'bx, 2'bxx, 1'bx, 1'bx, 1'bx, 2'bxx, 2'bxx, 5'bx, 5'bx, 5'bx);
        repeat (3) tick();
        checks++;
        if (bus.mem_memwrite !== 1'b0 || bus.wb_regwrite !== 1'b0) begin
            errors++; $display("[TB] FAIL xs_enables: got mw=%b rw=%b expected 0 0", bus.mem_memwrite, bus.wb_regwrite);
        end
        checks++;
        if ($isunknown(outs()) !== 1'b0) begin
            errors++; $display("[TB] FAIL xs_no_x: got %b expected no x", outs());
        end
        checks++;
        if (outs() !== BUBBLE_VEC) begin
            errors++; $display("[TB] FAIL xs_bubble: got %b expected %b", outs(), BUBBLE_VEC);
        end
        drain();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.ex_eq = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_jump_hazard();
        test_x_sanitise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Sequential consumer of the ID-stage control bundle produced by the opcode decoder.
- Carries that bundle down the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles; resolves branch/jump redirects in EX and flushes younger stages.
- Produces the EX-stage operand forwarding selects. Sits between the decoder and the datapath pipeline registers.

Parameters:
- RA_W, 5, register-address width (x0..x31).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_alusrc  in  1  decoded ALUSrc
- id_mem2reg  in  2  decoded Mem2Reg (REGALU/REGMEM/RPC)
- id_regwrite  in  1  decoded RegWrite
- id_memread  in  1  decoded MemRead
- id_memwrite  in  1  decoded MemWrite
- id_branch  in  2  decoded Branch (BCN/BCB/BCJAL/BCJALR)
- id_aluop  in  2  decoded ALUOp
- id_rs1, id_rs2, id_rd  in  RA_W each  ID register fields
- ex_eq  in  1  EX comparator result, rs1==rs2
- ex_alusrc, ex_aluop  out  1/2  EX-stage controls
- ex_branch  out  2  EX-stage branch class
- mem_memread, mem_memwrite  out  1 each  MEM-stage controls
- wb_regwrite  out  1  WB-stage write enable
- wb_mem2reg  out  2  WB-stage writeback source
- wb_rd  out  RA_W  WB destination register
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  squash IF/ID this cycle
- redirect  out  1  PC takes branch/jump target
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 from MEM, 01 from WB

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset: all stage registers are loaded with a bubble: valid=0, RegWrite=0, MemRead=0, MemWrite=0, Branch=BCN, ALUSrc=0, Mem2Reg=REGALU, ALUOp=2'b11, rd/rs1/rs2=0. Consequently all outputs are 0, except ex_aluop=2'b11 and wb_mem2reg=REGALU.
- Reset mid-operation clears every stage in the same instant. The pipeline restarts empty.
- Pipeline advance: each posedge, MEM/WB<=EX/MEM, EX/MEM<=ID/EX, and ID/EX<=ID inputs or a bubble.
- Latency: ID to EX is 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- Bubble into ID/EX when any of these holds: id_valid=0, stall=1, or redirect=1.
- Bubble sanitisation: the bubble values overwrite any x fields from the decoder, so x never reaches MEM/WB enables.
- Load-use stall (combinational):
  - stall = ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid & ~redirect.
  - Lasts exactly one cycle. After the bubble, the load is in MEM, so the condition clears and forwarding takes over.
- Redirect (combinational, from ID/EX state):
  - redirect = ex_valid & (ex_branch==BCJAL | ex_branch==BCJALR | (ex_branch==BCB & ex_eq)).
  - flush = redirect.
- Simultaneous redirect and hazard: redirect wins, stall=0. The ID instruction is squashed, not held.
- x0 rule: rd==0 never triggers a stall or forward. Stages with RegWrite=0 never forward.
- Forwarding for fwd_a (fwd_b is identical using ex_rs2):
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1;
  - else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00.
  - MEM has priority over WB.
- Stores and branches (RegWrite=0) travel normally and never write back.
- No FSM beyond the stage registers. Stall and flush are single-cycle pulses recomputed every cycle.

Decomposition:
- params.v (shared): Mem2Reg codes REGALU/REGMEM/RPC, Branch codes BCN/BCB/BCJAL/BCJALR, opcode constants, and the bubble ALUOp value 2'b11.
- Natural sub-module: ctrl_stage_reg, one pipeline register with a bubble-load input, instantiated three times.
- Hazard and forwarding logic stays in the top module.

Test Plan:
- Reset with a bundle present on the inputs: assert rst between edges -> all outputs take their bubble values immediately, with no clock edge required. Release rst with no valid instructions -> outputs stay at bubble values.
- Back-to-back dependency: add x5 then add x6,x5,x7 -> on the second instruction's EX cycle, fwd_a=10; with one independent instruction between them -> fwd_a=01; if rd=x0 -> fwd_a=00.
- Load-use: lw x5, then add x6,x5,x1 in ID -> stall=1 for exactly 1 cycle, and ex_* show a bubble next cycle. In the add's EX cycle, fwd_a=01 from WB.
- beq taken: ex_branch=BCB, ex_eq=1 -> redirect=flush=1 for 1 cycle, and the next ID/EX is a bubble (wb_regwrite=0 three cycles later). With ex_eq=0 -> redirect=0.
- jal/jalr in EX together with a load-use condition in ID -> redirect=1, stall=0. The jal reaches WB with wb_mem2reg=RPC, wb_regwrite=1.
- id_valid=0 with x on id_branch/id_mem2reg -> mem_memwrite=0 and wb_regwrite=0, with no x on any output.
